multiplier_datapath_32bit: RTL
==============================

# multiplier_datapath_32bit

Shift-add datapath for the 32-bit sequential multiplier, sitting directly downstream of `Control_32bit`. It holds the multiplicand and the 64-bit product/multiplier register, an iteration counter, and an add carry flag. Each clock it executes the load, add and shift commands issued by the control FSM. It returns the status bits the FSM branches on: `lsb` (current multiplier bit) and `lt` (iterations remaining).

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The product is `2*WIDTH` bits wide.

Ports:
- `clk` (input, 1): single clock. All state updates on the rising edge.
- `rst` (input, 1): reset, synchronous and active-high.
- `load` (input, 1): capture operands and start a new multiply.
- `add_en` (input, 1): add the multiplicand into the upper product half.
- `shift_en` (input, 1): shift `{carry, product}` right by 1 and increment the counter.
- `multiplicand_in` (input, 32): multiplicand, sampled on `load`.
- `multiplier_in` (input, 32): multiplier, sampled on `load`.
- `lsb` (output, 1): equals `product[0]`.
- `lt` (output, 1): 1 while `count < 32`.
- `product` (output, 64): product register. Holds the final result once `lt` = 0.

## Operation
- State registers:
  - `mcand[31:0]`
  - `product[63:0]`
  - `carry` (1 bit)
  - `count[5:0]`, saturating at 32
- Reset (`rst` = 1 at the edge): `mcand` = 0, `product` = 0, `carry` = 0, `count` = 0. Therefore `lsb` = 0 and `lt` = 1. Reset overrides every other input, including mid-operation; the partial result is discarded.
- Command priority: `rst` > `load` > (`add_en`, `shift_en`).
- Load:
  - `mcand` <= `multiplicand_in`
  - `product` <= {32'b0, `multiplier_in`}
  - `carry` <= 0, `count` <= 0
  - `add_en` and `shift_en` are ignored in that cycle.
- Add only (`add_en` = 1, `shift_en` = 0, `lt` = 1):
  - 33-bit sum `s` = `product[63:32]` + `mcand`
  - `product[63:32]` <= `s[31:0]`, `carry` <= `s[32]`
- Shift only (`shift_en` = 1, `add_en` = 0, `lt` = 1):
  - `product` <= {`carry`, `product[63:1]`}
  - `carry` <= 0, `count` <= `count` + 1
- Add and shift in the same cycle (`lt` = 1): the add and the shift are applied in one step.
  - `s` = `product[63:32]` + `mcand`
  - `product` <= {`s[32:0]`, `product[31:1]`}
  - `carry` <= 0, `count` += 1
- Either command with `lt` = 0 (`count` = 32): ignored, all state holds. The counter never exceeds 32 and never wraps.
- Arithmetic is unsigned. No overflow is possible because the 64-bit product holds the full 32x32 result.
- `lsb` and `lt` are combinational decodes of registered state only. There is no combinational path from the command inputs.

## Timing
- Every command takes effect at the edge where it is sampled. Its status outputs are valid in the following cycle, in time for the FSM's next decision.
- Fused schedule (one fused add/shift cycle per bit, with `add_en` = `lsb`): `lt` falls 32 cycles after the `load` edge, and `product` is final on that same edge.
- Split schedule (add cycle, then shift cycle): 32 shift cycles plus one add cycle per set multiplier bit. The result is identical to the fused schedule.
- A separate add leaves a pending `carry` that is consumed by the next shift. If two adds occur without an intervening shift, the second overwrites `carry`; this is a control error and the datapath does not flag it.
- A `load` asserted while a multiply is in progress restarts cleanly on that edge.

## Test plan
1. Reset: hold `rst` = 1 for 2 cycles with all commands asserted -> `product` = 0, `lt` = 1, `lsb` = 0. Release `rst` with commands idle -> outputs hold.
2. Fused multiply: `load` 6 x 7, then 32 cycles of `shift_en` = 1 with `add_en` = `lsb` -> `product` = 64'd42, `lt` = 0 exactly 32 cycles after the load.
3. Carry path: `load` 0xFFFFFFFF x 0xFFFFFFFF, fused schedule -> `product` = 64'hFFFFFFFE_00000001. Repeat with the split schedule -> same value.
4. Saturation: after the multiply in scenario 2, assert `shift_en` and `add_en` for 5 more cycles -> `product` stays 42 and `lt` stays 0.
5. Mid-operation events:
   - Assert `rst` after 10 iterations of 0x12345678 x 0x9ABCDEF0 -> all state is 0.
   - Then `load` 0xFFFF x 0x10001 with `add_en` and `shift_en` also high -> `load` wins, `count` = 0, `product` = 64'h0000_0000_0001_0001.
   - Completing that multiply -> `product` = 64'h0000_0000_FFFF_FFFF.
6. Randomized: 200 random operand pairs, each run with a randomly chosen fused or split schedule -> `product` = `multiplicand` * `multiplier` as 64-bit unsigned, and `lt` falls after exactly 32 shifts.

Source files
------------

// File: rtl/multiplier_datapath_32bit_if.sv
// Command/status bundle between the multiplier control FSM and the shift-add datapath.
// The master drives commands and operands; the slave returns status and the product.
interface multiplier_datapath_32bit_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 load;
    logic                 add_en;
    logic                 shift_en;
    logic [WIDTH-1:0]     multiplicand_in;
    logic [WIDTH-1:0]     multiplier_in;
    logic                 lsb;
    logic                 lt;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output load,
        output add_en,
        output shift_en,
        output multiplicand_in,
        output multiplier_in,
        input  lsb,
        input  lt,
        input  product
    );

    modport slave (
        input  load,
        input  add_en,
        input  shift_en,
        input  multiplicand_in,
        input  multiplier_in,
        output lsb,
        output lt,
        output product
    );
endinterface

// File: rtl/multiplier_datapath_32bit.sv
// Shift-add datapath for the sequential multiplier: multiplicand, product/multiplier
// register, add carry and a saturating iteration counter driven by load/add/shift commands.
module multiplier_datapath_32bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    multiplier_datapath_32bit_if.slave    bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CountMax = CntW'(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               carry_q, carry_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [WIDTH:0]     sum;
    logic               active;

    assign active = (count_q < CountMax);
    assign sum    = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

    always_comb begin
        mcand_d   = mcand_q;
        product_d = product_q;
        carry_d   = carry_q;
        count_d   = count_q;
        if (bus.load) begin
            mcand_d   = bus.multiplicand_in;
            product_d = {{WIDTH{1'b0}}, bus.multiplier_in};
            carry_d   = 1'b0;
            count_d   = '0;
        end else if (active) begin
            unique case ({bus.add_en, bus.shift_en})
                2'b10: begin
                    // Carry is parked until the next shift consumes it.
                    product_d[2*WIDTH-1:WIDTH] = sum[WIDTH-1:0];
                    carry_d                    = sum[WIDTH];
                end
                2'b01: begin
                    product_d = {carry_q, product_q[2*WIDTH-1:1]};
                    carry_d   = 1'b0;
                    count_d   = count_q + 1'b1;
                end
                2'b11: begin
                    product_d = {sum, product_q[WIDTH-1:1]};
                    carry_d   = 1'b0;
                    count_d   = count_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            product_q <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            mcand_q   <= mcand_d;
            product_q <= product_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
        end
    end

    // Status is decoded from registered state only, never from the commands.
    assign bus.lsb     = product_q[0];
    assign bus.lt      = active;
    assign bus.product = product_q;

    count_never_exceeds_width : assert property (@(posedge clk) count_q <= CountMax);
endmodule
